// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit that sits beside the single-cycle
// ALU in the execute stage. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU,
// retiring one bit per clock. The hazard unit stalls the pipe while busy=1.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset (wins over flush and start)
//   start  in   1      request, accepted in IDLE or DONE
//   flush  in   1      abort the operation in flight
//   A      in   WIDTH  rs1 (multiplicand / dividend)
//   B      in   WIDTH  rs2 (multiplier / divisor)
//   mdOp   in   3      RV funct3 of the M-extension instruction
//   busy   out  1      high while an operation is being computed
//   done   out  1      one-cycle pulse when mdRes holds a new result
//   mdRes  out  WIDTH  result, held until the next result is produced
//
// State | meaning
// IDLE  | waiting for start
// CALC  | one prep cycle (magnitudes), then WIDTH shift-add / restoring steps
// DONE  | result valid for one cycle; start here chains the next operation

module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       mdOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mdRes
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  stateT            state;
  logic [CW-1:0]    cnt;
  logic             prep;
  logic [2:0]       opReg;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] magOp;

  logic               isDiv;
  logic               sgnA;
  logic               sgnB;
  logic               aNeg;
  logic               bNeg;
  logic               bZero;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   nextHi;
  logic [WIDTH-1:0]   nextLo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodAdj;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   result;

  // Multiply: hi:lo holds {partial sum, remaining multiplier bits}; magOp is the
  // multiplicand. Divide: hi is the partial remainder, lo shifts dividend bits
  // out and quotient bits in; magOp is the divisor.
  always_comb begin
    isDiv = opReg[2];
    // MULH (01) and MULHSU (10) treat A as signed; only MULH treats B as signed.
    // MUL is computed unsigned since its low half is sign-independent.
    sgnA  = isDiv ? ~opReg[0] : (opReg[1] ^ opReg[0]);
    sgnB  = isDiv ? ~opReg[0] : (~opReg[1] & opReg[0]);
    aNeg  = sgnA & aReg[WIDTH-1];
    bNeg  = sgnB & bReg[WIDTH-1];
    bZero = (bReg == '0);
    absA  = aNeg ? -aReg : aReg;
    absB  = bNeg ? -bReg : bReg;

    sum     = {1'b0, hi} + {1'b0, magOp};
    shifted = {hi, lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, magOp});

    if (isDiv) begin
      // When ge is set the difference is below magOp, so the low bits are exact.
      nextHi = ge ? (shifted[WIDTH-1:0] - magOp) : shifted[WIDTH-1:0];
      nextLo = {lo[WIDTH-2:0], ge};
    end else if (lo[0]) begin
      nextHi = sum[WIDTH:1];
      nextLo = {sum[0], lo[WIDTH-1:1]};
    end else begin
      nextHi = {1'b0, hi[WIDTH-1:1]};
      nextLo = {hi[0], lo[WIDTH-1:1]};
    end

    prod    = {nextHi, nextLo};
    prodAdj = (aNeg ^ bNeg) ? -prod : prod;
    // Divide by zero yields an all-ones quotient regardless of sign; the
    // MIN / -1 overflow case falls out of the magnitude arithmetic naturally.
    quo     = ((aNeg ^ bNeg) && !bZero) ? -nextLo : nextLo;
    rem     = aNeg ? -nextHi : nextHi;

    case (opReg)
      3'b000:                 result = prodAdj[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result = prodAdj[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      mdRes <= '0;
      cnt   <= '0;
      prep  <= 1'b0;
      opReg <= '0;
      aReg  <= '0;
      bReg  <= '0;
      hi    <= '0;
      lo    <= '0;
      magOp <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (!flush && start) begin
            opReg <= mdOp;
            aReg  <= A;
            bReg  <= B;
            cnt   <= '0;
            prep  <= 1'b1;
            busy  <= 1'b1;
            state <= CALC;
          end
        end

        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            prep  <= 1'b0;
            state <= IDLE;
          end else if (prep) begin
            prep  <= 1'b0;
            hi    <= '0;
            lo    <= isDiv ? absA : absB;
            magOp <= isDiv ? absB : absA;
          end else begin
            hi <= nextHi;
            lo <= nextLo;
            if (cnt == CW'(WIDTH-1)) begin
              mdRes <= result;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        DONE: begin
          done <= 1'b0;
          if (!flush && start) begin
            opReg <= mdOp;
            aReg  <= A;
            bReg  <= B;
            cnt   <= '0;
            prep  <= 1'b1;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv (WIDTH=32): expected results are queued when an
// operation is issued and popped by a monitor when done pulses.

module tb_alu_muldiv;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic         flush;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   mdOp;
  logic         busy;
  logic         done;
  logic [W-1:0] mdRes;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } expT;

  expT          expQ[$];
  int           nCmp = 0;
  int           nMis = 0;
  logic [W-1:0] lastRes = '0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .A     (A),
    .B     (B),
    .mdOp  (mdOp),
    .busy  (busy),
    .done  (done),
    .mdRes (mdRes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint          sa, sbv, ua, ub, p;
    longint unsigned up, uau, ubu;
    logic [W-1:0]    r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    uau = {32'h0, a};
    ubu = {32'h0, b};
    r   = '0;
    case (op)
      3'd0: begin p = ua * ub;   r = p[31:0];  end
      3'd1: begin p = sa * sbv;  r = p[63:32]; end
      3'd2: begin p = sa * ub;   r = p[63:32]; end
      3'd3: begin up = uau * ubu; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == '1) r = 32'h8000_0000;
        else begin p = sa / sbv; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == '1) r = '0;
        else begin p = sa % sbv; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (done) begin
        check("doneWithBusy", {63'b0, busy}, 64'd0);
        if (expQ.size() == 0) begin
          check("unexpectedDone", {63'b0, done}, 64'd0);
        end else begin
          e = expQ.pop_front();
          check(e.tag, {32'b0, mdRes}, {32'b0, e.val});
          lastRes = e.val;
        end
      end
    end
  end

  // Drive a request; when now=1 the caller is already at a falling edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input bit push, input bit now);
    expT e;
    if (!now) @(negedge clk);
    start = 1'b1;
    mdOp  = op;
    A     = a;
    B     = b;
    if (push) begin
      e.tag = tag;
      e.val = model(op, a, b);
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    mdOp  = 3'($urandom_range(0, 7));
  endtask

  // Counts rising edges after the accepting edge until done is seen.
  task automatic waitDone(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (done) break;
      if (lat == 0) check("busyFirst", {63'b0, busy}, 64'd1);
      @(posedge clk);
      lat++;
    end
    if (lat >= 100) check("doneTimeout", {63'b0, done}, 64'd1);
  endtask

  task automatic runOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    int lat;
    issue(op, a, b, tag, 1'b1, 1'b0);
    waitDone(lat);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    @(negedge clk);
    check({tag, "_doneDrop"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    int lat;
    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    A     = '0;
    B     = '0;
    mdOp  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstBusy", {63'b0, busy}, 64'd0);
    check("rstDone", {63'b0, done}, 64'd0);
    check("rstRes", {32'b0, mdRes}, 64'd0);
    rst = 1'b0;

    runOp(3'd0, 32'd7, 32'd3, "mul7x3");
    runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    runOp(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");
    runOp(3'd4, 32'hFFFF_FFF9, 32'd2, "divNeg");
    runOp(3'd6, 32'hFFFF_FFF9, 32'd2, "remNeg");
    runOp(3'd5, 32'd7, 32'd2, "divu");
    runOp(3'd7, 32'd7, 32'd2, "remu");
    runOp(3'd5, 32'd5, 32'd0, "divuZero");
    runOp(3'd7, 32'd5, 32'd0, "remuZero");
    runOp(3'd4, 32'hFFFF_FFF9, 32'd0, "divZero");
    runOp(3'd6, 32'hFFFF_FFF9, 32'd0, "remZero");
    runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "divOvf");
    runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "remOvf");
    runOp(3'd1, 32'h8000_0000, 32'h8000_0000, "mulhMin");

    // start pulsed mid-CALC is ignored
    issue(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, "midStart", 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    mdOp  = 3'd4;
    A     = 32'd100;
    B     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat);
    check("midStart_lat", 64'(lat), 64'(LAT - 6));
    @(negedge clk);
    check("midStart_doneDrop", {63'b0, done}, 64'd0);

    // back-to-back: start presented during the DONE cycle
    issue(3'd0, 32'hFFFF_FFFD, 32'd11, "b2bFirst", 1'b1, 1'b0);
    waitDone(lat);
    check("b2bFirst_lat", 64'(lat), 64'(LAT));
    issue(3'd6, 32'hFFFF_FF9C, 32'd7, "b2bSecond", 1'b1, 1'b1);
    waitDone(lat);
    check("b2bSecond_lat", 64'(lat), 64'(LAT));
    @(negedge clk);
    check("b2bSecond_doneDrop", {63'b0, done}, 64'd0);

    // reset in the middle of an operation
    issue(3'd4, 32'd1000, 32'd3, "rstMid", 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstMidBusy", {63'b0, busy}, 64'd0);
    check("rstMidDone", {63'b0, done}, 64'd0);
    check("rstMidRes", {32'b0, mdRes}, 64'd0);
    repeat (40) @(negedge clk);
    check("rstMidIdle", {63'b0, busy}, 64'd0);

    // flush in the middle of an operation keeps the previous result
    runOp(3'd5, 32'd7, 32'd2, "preFlush");
    issue(3'd0, 32'd9, 32'd9, "flushMid", 1'b0, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flushBusy", {63'b0, busy}, 64'd0);
    check("flushDone", {63'b0, done}, 64'd0);
    check("flushRes", {32'b0, mdRes}, {32'b0, lastRes});
    repeat (40) @(negedge clk);
    check("flushResHeld", {32'b0, mdRes}, {32'b0, lastRes});

    // random operations
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = (i == 3) ? '0 : $urandom;
      if (i == 5) rb = 32'($urandom_range(1, 15));
      runOp(3'($urandom_range(0, 7)), ra, rb, "rand");
    end

    repeat (3) @(negedge clk);
    check("queueEmpty", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
